seg_scan_mux: RTL and testbench

- Parametrised N-digit time-multiplexed 7-segment scan controller; successor to the two-digit toggling display driver.
- Per-digit enable and a programmable dead-time blanking slot between digits to suppress ghosting through the anode transistors.
- Double-buffered digit load with a frame-boundary commit, so the display never tears.
- Registered enabled-digit sum output for the LED bar.
- Sits between the input/switch logic and the downstream hex-to-segment decoder and anode transistor drivers.

---
 rtl/seg_scan_pkg.sv | 30 +++
 rtl/seg_scan_mux_if.sv | 36 +++
 rtl/scan_timer.sv | 86 ++++++++
 rtl/seg_scan_mux.sv | 103 ++++++++++
 tb/tb_seg_scan_mux.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the seg_scan_mux display scanner.
//   scan_state_t : scan FSM states (BLANK dead-time, SHOW anode on)
//   nibble_t     : one hex digit
//   onehot()     : anode mask for a digit index, zero if idx >= n
//   sum_width()  : width of the enabled-digit sum for n digits
package seg_scan_pkg;

    localparam int unsigned MAX_DIGITS = 8;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    typedef logic [3:0] nibble_t;

    // One-hot anode mask; out-of-range indices give an all-off mask.
    function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx, input int unsigned n);
        if (idx < n) begin
            return MAX_DIGITS'(1) << idx;
        end
        return '0;
    endfunction

    // Enough bits for n digits all at 15.
    function automatic int unsigned sum_width(input int unsigned n);
        return $clog2(15 * n + 1);
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Bus between the switch/input logic, the scanner and the display drivers.
//   digits_in  : packed hex nibbles, digit k at [4k+3:4k]
//   digit_en   : live per-digit enable
//   load       : strobe capturing digits_in into staging
//   pending    : staged data waiting for the frame boundary
//   frame_done : one-cycle pulse on commit
//   sout       : nibble of the scanned digit
//   anode_en   : one-hot anode drive, zero during blanking
//   leds       : sum of enabled committed digits
interface seg_scan_mux_if #(
    parameter int unsigned N_DIGITS = 4
);
    import seg_scan_pkg::*;

    localparam int unsigned SUM_W = sum_width(N_DIGITS);

    logic [4*N_DIGITS-1:0] digits_in;
    logic [N_DIGITS-1:0]   digit_en;
    logic                  load;
    logic                  pending;
    logic                  frame_done;
    nibble_t               sout;
    logic [N_DIGITS-1:0]   anode_en;
    logic [SUM_W-1:0]      leds;

    modport master (
        output digits_in, digit_en, load,
        input  pending, frame_done, sout, anode_en, leds
    );

    modport slave (
        input  digits_in, digit_en, load,
        output pending, frame_done, sout, anode_en, leds
    );

endinterface

// File: rtl/scan_timer.sv
// Slot timer for the display scan: dead-time then hold for each digit.
//   clk, reset_n  : clock, async active-low reset
//   show_nxt_c_o  : FSM will be in SHOW after this edge
//   adv_c_o       : SHOW->BLANK this edge (index advances)
//   wrap_c_o      : advance from the last digit back to digit 0
//   idx_o         : current digit index (registered)
//   idx_nxt_c_o   : digit index after this edge
module scan_timer
    import seg_scan_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned HOLD_CYCLES = 4096,
    parameter int unsigned DEAD_CYCLES = 64,
    localparam int unsigned IDX_W      = $clog2(N_DIGITS)
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             show_nxt_c_o,
    output logic             adv_c_o,
    output logic             wrap_c_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [IDX_W-1:0] idx_nxt_c_o
);

    localparam int unsigned MAX_CYC = (HOLD_CYCLES > DEAD_CYCLES) ? HOLD_CYCLES : DEAD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             adv_c, wrap_c;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: count out the slot, then flip and restart the counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        adv_c   = 1'b0;
        wrap_c  = 1'b0;
        case (state_q)
            BLANK: begin
                if (cnt_q == CNT_W'(DEAD_CYCLES - 1)) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    adv_c   = 1'b1;
                    if (idx_q == IDX_W'(N_DIGITS - 1)) begin
                        idx_d  = '0;
                        wrap_c = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    assign show_nxt_c_o = (state_d == SHOW);
    assign adv_c_o      = adv_c;
    assign wrap_c_o     = wrap_c;
    assign idx_o        = idx_q;
    assign idx_nxt_c_o  = idx_d;

endmodule

// File: rtl/seg_scan_mux.sv
// N-digit time-multiplexed 7-segment scan controller with dead-time
// blanking, per-digit enable, double-buffered load and an LED-bar sum.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : digits_in/digit_en/load in; pending/frame_done/sout/
//                  anode_en/leds out, all outputs registered
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned HOLD_CYCLES = 4096,
    parameter int unsigned DEAD_CYCLES = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    seg_scan_mux_if.slave bus
);

    localparam int unsigned SUM_W = sum_width(N_DIGITS);
    localparam int unsigned IDX_W = $clog2(N_DIGITS);
    localparam int unsigned DW    = 4 * N_DIGITS;

    logic             show_nxt_c, adv_c, wrap_c;
    logic [IDX_W-1:0] idx, idx_nxt_c;

    logic [DW-1:0]       staging_q, staging_d;
    logic [DW-1:0]       shadow_q, shadow_d;
    logic                pending_q, pending_d;
    logic                frame_done_q, frame_done_d;
    nibble_t             sout_q, sout_d;
    logic [N_DIGITS-1:0] anode_q, anode_d;
    logic [SUM_W-1:0]    leds_q, leds_d;
    logic                commit_c;

    scan_timer #(
        .N_DIGITS    (N_DIGITS),
        .HOLD_CYCLES (HOLD_CYCLES),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .show_nxt_c_o (show_nxt_c),
        .adv_c_o      (adv_c),
        .wrap_c_o     (wrap_c),
        .idx_o        (idx),
        .idx_nxt_c_o  (idx_nxt_c)
    );

    // Buffering, commit at the frame wrap, output muxing and LED sum
    always_comb begin
        commit_c     = wrap_c & pending_q;
        staging_d    = bus.load ? bus.digits_in : staging_q;
        shadow_d     = commit_c ? staging_q : shadow_q;
        // A load on the commit edge re-arms pending for the next wrap
        pending_d    = bus.load | (pending_q & ~commit_c);
        frame_done_d = commit_c;

        // New digit's nibble lands at the start of its dead time
        sout_d = sout_q;
        if (adv_c) begin
            sout_d = shadow_d[{idx_nxt_c, 2'b00} +: 4];
        end

        anode_d = '0;
        if (show_nxt_c) begin
            anode_d = N_DIGITS'(onehot(32'(idx), N_DIGITS)) & bus.digit_en;
        end

        leds_d = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (bus.digit_en[k]) begin
                leds_d = leds_d + SUM_W'(shadow_q[4*k +: 4]);
            end
        end
    end

    // Output and buffer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            staging_q    <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            sout_q       <= '0;
            anode_q      <= '0;
            leds_q       <= '0;
        end else begin
            staging_q    <= staging_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            sout_q       <= sout_d;
            anode_q      <= anode_d;
            leds_q       <= leds_d;
        end
    end

    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sout       = sout_q;
    assign bus.anode_en   = anode_q;
    assign bus.leds       = leds_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with N_DIGITS=4, HOLD=4, DEAD=2.
// cyc counts rising edges since reset release; values are sampled 1 time
// unit after each edge. Slot position p = cyc%6 (0,1 blank; 2..5 show),
// slot digit s = (cyc/6)%4, commits happen on edges where cyc%24 == 0.
module tb_seg_scan_mux;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc;
    int   checks   = 0;
    int   failures = 0;

    seg_scan_mux_if #(.N_DIGITS(4)) bus ();

    seg_scan_mux #(
        .N_DIGITS    (4),
        .HOLD_CYCLES (4),
        .DEAD_CYCLES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.digit_en  = 4'b1111;
        tick();
        tick();
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    function automatic logic [3:0] exp_anode(input int k, input logic [3:0] en);
        int p;
        int s;
        logic [3:0] oh;
        p  = k % 6;
        s  = (k / 6) % 4;
        oh = 4'b0001 << s;
        return (p >= 2) ? (oh & en) : 4'b0000;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (bus.anode_en !== 4'b0) begin failures++; $display("FAIL reset_anode got=%b exp=0000", bus.anode_en); end
        checks++; if (bus.sout !== 4'h0) begin failures++; $display("FAIL reset_sout got=%h exp=0", bus.sout); end
        checks++; if (bus.pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", bus.pending); end
        checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", bus.frame_done); end
        checks++; if (bus.leds !== 6'd0) begin failures++; $display("FAIL reset_leds got=%0d exp=0", bus.leds); end
        for (int k = 1; k <= 26; k++) begin
            tick();
            checks++;
            if (bus.anode_en !== exp_anode(cyc, 4'b1111)) begin
                failures++;
                $display("FAIL scan_anode cyc=%0d got=%b exp=%b", cyc, bus.anode_en, exp_anode(cyc, 4'b1111));
            end
        end
    endtask

    task automatic test_load_commit();
        do_reset();
        run_to(10);
        bus.load = 1'b1; bus.digits_in = 16'hA3F1;
        tick();
        bus.load = 1'b0;
        checks++; if (bus.pending !== 1'b1) begin failures++; $display("FAIL lc_pending_set got=%b exp=1", bus.pending); end
        checks++; if (bus.sout !== 4'h0) begin failures++; $display("FAIL lc_sout_hold got=%h exp=0", bus.sout); end
        run_to(23);
        checks++; if (bus.frame_done !== 1'b0 || bus.pending !== 1'b1) begin failures++; $display("FAIL lc_prewrap fd=%b pend=%b exp fd=0 pend=1", bus.frame_done, bus.pending); end
        tick();
        checks++; if (bus.frame_done !== 1'b1) begin failures++; $display("FAIL lc_frame_done got=%b exp=1", bus.frame_done); end
        checks++; if (bus.pending !== 1'b0) begin failures++; $display("FAIL lc_pending_clr got=%b exp=0", bus.pending); end
        checks++; if (bus.sout !== 4'h1) begin failures++; $display("FAIL lc_sout_d0 got=%h exp=1", bus.sout); end
        tick();
        checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL lc_fd_pulse got=%b exp=0", bus.frame_done); end
        checks++; if (bus.leds !== 6'd29) begin failures++; $display("FAIL lc_leds got=%0d exp=29", bus.leds); end
        run_to(26);
        checks++; if (bus.anode_en !== 4'b0001) begin failures++; $display("FAIL lc_anode got=%b exp=0001", bus.anode_en); end
        run_to(30);
        checks++; if (bus.sout !== 4'hF) begin failures++; $display("FAIL lc_sout_d1 got=%h exp=F", bus.sout); end
        run_to(36);
        checks++; if (bus.sout !== 4'h3) begin failures++; $display("FAIL lc_sout_d2 got=%h exp=3", bus.sout); end
        run_to(42);
        checks++; if (bus.sout !== 4'hA) begin failures++; $display("FAIL lc_sout_d3 got=%h exp=A", bus.sout); end
    endtask

    task automatic test_digit_enable();
        run_to(48);
        bus.digit_en = 4'b0101;
        tick();
        checks++; if (bus.leds !== 6'd4) begin failures++; $display("FAIL en_leds got=%0d exp=4", bus.leds); end
        for (int k = 50; k <= 72; k++) begin
            tick();
            checks++;
            if (bus.anode_en !== exp_anode(cyc, 4'b0101)) begin
                failures++;
                $display("FAIL en_anode cyc=%0d got=%b exp=%b", cyc, bus.anode_en, exp_anode(cyc, 4'b0101));
            end
        end
        bus.digit_en = 4'b1111;
    endtask

    task automatic test_load_on_wrap();
        do_reset();
        run_to(5);
        bus.load = 1'b1; bus.digits_in = 16'h1111;
        tick();
        bus.load = 1'b0;
        run_to(23);
        bus.load = 1'b1; bus.digits_in = 16'h2222;
        tick();
        bus.load = 1'b0;
        checks++; if (bus.frame_done !== 1'b1) begin failures++; $display("FAIL wrap_fd1 got=%b exp=1", bus.frame_done); end
        checks++; if (bus.pending !== 1'b1) begin failures++; $display("FAIL wrap_pending got=%b exp=1", bus.pending); end
        checks++; if (bus.sout !== 4'h1) begin failures++; $display("FAIL wrap_sout1 got=%h exp=1", bus.sout); end
        tick();
        checks++; if (bus.leds !== 6'd4) begin failures++; $display("FAIL wrap_leds1 got=%0d exp=4", bus.leds); end
        run_to(47);
        checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL wrap_fd_idle got=%b exp=0", bus.frame_done); end
        tick();
        checks++; if (bus.frame_done !== 1'b1 || bus.pending !== 1'b0) begin failures++; $display("FAIL wrap_fd2 fd=%b pend=%b exp fd=1 pend=0", bus.frame_done, bus.pending); end
        checks++; if (bus.sout !== 4'h2) begin failures++; $display("FAIL wrap_sout2 got=%h exp=2", bus.sout); end
        tick();
        checks++; if (bus.leds !== 6'd8) begin failures++; $display("FAIL wrap_leds2 got=%0d exp=8", bus.leds); end
    endtask

    task automatic test_overwrite();
        int pulses;
        pulses = 0;
        run_to(50);
        bus.load = 1'b1; bus.digits_in = 16'h0001;
        tick();
        bus.load = 1'b0;
        run_to(55);
        bus.load = 1'b1; bus.digits_in = 16'hFFFF;
        tick();
        bus.load = 1'b0;
        while (cyc < 95) begin
            tick();
            if (bus.frame_done === 1'b1) pulses++;
            if (cyc == 72) begin
                checks++;
                if (bus.sout !== 4'hF) begin failures++; $display("FAIL ow_sout got=%h exp=F", bus.sout); end
            end
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL ow_pulses got=%0d exp=1", pulses); end
        checks++; if (bus.leds !== 6'd60) begin failures++; $display("FAIL ow_leds got=%0d exp=60", bus.leds); end
    endtask

    task automatic test_mid_show_reset();
        run_to(97);
        bus.load = 1'b1; bus.digits_in = 16'h5555;
        tick();
        bus.load = 1'b0;
        checks++; if (bus.pending !== 1'b1) begin failures++; $display("FAIL rst_pending_pre got=%b exp=1", bus.pending); end
        run_to(110);
        checks++; if (bus.anode_en !== 4'b0100) begin failures++; $display("FAIL rst_anode_pre got=%b exp=0100", bus.anode_en); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.anode_en !== 4'b0 || bus.sout !== 4'h0 || bus.pending !== 1'b0 ||
            bus.frame_done !== 1'b0 || bus.leds !== 6'd0) begin
            failures++;
            $display("FAIL rst_async an=%b sout=%h pend=%b fd=%b leds=%0d exp all 0",
                     bus.anode_en, bus.sout, bus.pending, bus.frame_done, bus.leds);
        end
        tick();
        tick();
        reset_n = 1'b1;
        cyc     = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (bus.anode_en !== exp_anode(cyc, 4'b1111)) begin
                failures++;
                $display("FAIL rst_rescan cyc=%0d got=%b exp=%b", cyc, bus.anode_en, exp_anode(cyc, 4'b1111));
            end
        end
        checks++; if (bus.pending !== 1'b0) begin failures++; $display("FAIL rst_pending_post got=%b exp=0", bus.pending); end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.digit_en  = 4'b1111;
        cyc           = 0;
        test_reset();
        test_load_commit();
        test_digit_enable();
        test_load_on_wrap();
        test_overwrite();
        test_mid_show_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
